// File: rtl/proc_pkg.sv
// Shared definitions for the fetch/decode front end: FSM encoding and
// instruction field positions.
package proc_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned RDEST_MSB = 11;
  localparam int unsigned EXT_MSB   = 7;
  localparam int unsigned RSRC_MSB  = 3;
  localparam int unsigned FIELD_W   = 4;
  localparam int unsigned IMM_W     = 8;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with parallel load and modulo-2^ADDR_WIDTH increment.
module pc_reg
  import proc_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] load_val_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  // Load wins over increment; increment wraps naturally at the register width.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch over a valid-strobed memory read, instruction register,
// field decode, and PC redirect/flush handling.
module instr_fetch_decode
  import proc_pkg::*;
#(
  parameter int unsigned           WIDTH      = INSTR_W,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_valid,
  output logic                  instr_valid,
  input  logic                  instr_ack,
  input  logic                  branch_taken,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [FIELD_W-1:0]    opCode,
  output logic [FIELD_W-1:0]    rdest,
  output logic [FIELD_W-1:0]    opExt,
  output logic [FIELD_W-1:0]    rsrc_imm,
  output logic [IMM_W-1:0]      imm8
);

  state_e           state_q;
  logic [WIDTH-1:0] ir_q;
  logic             squash_q;
  logic             mem_req_q;
  logic             instr_valid_q;
  logic             pc_load;
  logic             pc_inc;

  // PC update: flush beats ack; ack only counts while an instruction is held.
  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    if (flush) begin
      pc_load = 1'b1;
    end else if ((state_q == ISSUE) && instr_ack) begin
      pc_load = branch_taken;
      pc_inc  = !branch_taken;
    end
  end

  pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (pc_load),
    .load_val_i (branch_target),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  // squash_q marks an outstanding response that belongs to a pre-flush address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= FETCH;
      ir_q          <= '0;
      squash_q      <= 1'b0;
      mem_req_q     <= 1'b1;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (flush) begin
            squash_q <= !mem_valid;
          end else if (mem_valid) begin
            if (squash_q) begin
              squash_q <= 1'b0;
            end else begin
              ir_q          <= mem_rdata;
              state_q       <= ISSUE;
              mem_req_q     <= 1'b0;
              instr_valid_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (flush || instr_ack) begin
            state_q       <= FETCH;
            mem_req_q     <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc;
  assign instr_valid = instr_valid_q;
  assign opCode      = ir_q[OP_MSB -: FIELD_W];
  assign rdest       = ir_q[RDEST_MSB -: FIELD_W];
  assign opExt       = ir_q[EXT_MSB -: FIELD_W];
  assign rsrc_imm    = ir_q[RSRC_MSB -: FIELD_W];
  assign imm8        = ir_q[EXT_MSB -: IMM_W];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed plus randomized bench for instr_fetch_decode with a latency-
// programmable memory and a program-flow reference model.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_valid = 1'b0;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic        branch_taken = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] pc;
  logic [3:0]  opCode;
  logic [3:0]  rdest;
  logic [3:0]  opExt;
  logic [3:0]  rsrc_imm;
  logic [7:0]  imm8;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_pc = 16'h0000;

  logic [15:0] mem_over [int];
  int          lat = 2;
  int          cnt = 0;
  logic [15:0] lat_addr = 16'h0000;

  always #5 clk = ~clk;

  instr_fetch_decode #(
    .WIDTH      (16),
    .ADDR_WIDTH (16),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_valid     (mem_valid),
    .instr_valid   (instr_valid),
    .instr_ack     (instr_ack),
    .branch_taken  (branch_taken),
    .flush         (flush),
    .branch_target (branch_target),
    .pc            (pc),
    .opCode        (opCode),
    .rdest         (rdest),
    .opExt         (opExt),
    .rsrc_imm      (rsrc_imm),
    .imm8          (imm8)
  );

  // Program contents: explicit words where tests need them, a hash elsewhere.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_over.exists(int'(a))) return mem_over[int'(a)];
    return (a * 16'd40503) ^ 16'h5A5A;
  endfunction

  // Memory: address captured at request start, one-cycle valid after lat edges.
  always @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= 0;
      mem_valid <= 1'b0;
    end else if (mem_valid) begin
      mem_valid <= 1'b0;
      cnt       <= 0;
    end else if (mem_req) begin
      if (cnt == 0) lat_addr <= mem_addr;
      if (cnt + 1 >= lat) begin
        mem_valid <= 1'b1;
        mem_rdata <= mem_word(cnt == 0 ? mem_addr : lat_addr);
        cnt       <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  // Fields of the held instruction must be those of the word at address a.
  task automatic check_issue(input logic [15:0] a);
    int w;
    w = int'(mem_word(a));
    chk("iss_valid", 32'(instr_valid), 32'd1);
    chk("iss_req",   32'(mem_req), 32'd0);
    chk("iss_pc",    32'(pc), 32'(a));
    chk("iss_op",    32'(opCode), 32'(w / 4096));
    chk("iss_rdest", 32'(rdest), 32'((w / 256) % 16));
    chk("iss_ext",   32'(opExt), 32'((w / 16) % 16));
    chk("iss_rsrc",  32'(rsrc_imm), 32'(w % 16));
    chk("iss_imm8",  32'(imm8), 32'(w % 256));
  endtask

  task automatic do_ack(input logic br, input logic [15:0] tgt);
    instr_ack     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    @(negedge clk);
    instr_ack    = 1'b0;
    branch_taken = 1'b0;
    exp_pc = br ? tgt : exp_pc + 16'd1;
    chk("ack_req",   32'(mem_req), 32'd1);
    chk("ack_addr",  32'(mem_addr), 32'(exp_pc));
    chk("ack_valid", 32'(instr_valid), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_pc"},    32'(pc), 32'd0);
    chk({tag, "_op"},    32'(opCode), 32'd0);
    chk({tag, "_rdest"}, 32'(rdest), 32'd0);
    chk({tag, "_ext"},   32'(opExt), 32'd0);
    chk({tag, "_rsrc"},  32'(rsrc_imm), 32'd0);
    chk({tag, "_imm8"},  32'(imm8), 32'd0);
    chk({tag, "_req"},   32'(mem_req), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          k;
    logic        br;
    logic [15:0] tgt;

    mem_over[0]         = 16'h5A83;
    mem_over[32'hFFFF]  = 16'hFFFF;

    // Reset and first fetch with latency 2.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset_n = 1'b1;
    exp_pc  = 16'h0000;
    @(negedge clk);
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'h0000);
    chk("first_v1", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("first_v2", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("first_v3", 32'(instr_valid), 32'd1);
    check_issue(16'h0000);
    chk("first_op_lit", 32'(opCode), 32'h5);
    chk("first_imm_lit", 32'(imm8), 32'h83);

    // Taken branch, then sequential step.
    do_ack(1'b1, 16'h0040);
    wait_issue("wait_40");
    check_issue(16'h0040);
    do_ack(1'b0, 16'h1234);
    wait_issue("wait_41");
    check_issue(16'h0041);

    // Stall in ISSUE: everything frozen, no requests.
    w = int'(mem_word(16'h0041));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_req",   32'(mem_req), 32'd0);
      chk("hold_fields", {16'h0, opCode, rdest, opExt, rsrc_imm}, 32'(w));
    end

    // Flush together with ack: redirect wins, no sequential step.
    flush = 1'b1; instr_ack = 1'b1; branch_taken = 1'b0; branch_target = 16'h0200;
    @(negedge clk);
    flush = 1'b0; instr_ack = 1'b0;
    exp_pc = 16'h0200;
    chk("fa_req", 32'(mem_req), 32'd1);
    chk("fa_addr", 32'(mem_addr), 32'h0200);
    wait_issue("wait_200");
    check_issue(16'h0200);

    // Flush one cycle into a latency-3 fetch: the stale word is dropped.
    lat = 3;
    do_ack(1'b0, 16'h0000);
    @(negedge clk);
    flush = 1'b1; branch_target = 16'h0100;
    @(negedge clk);
    flush = 1'b0;
    exp_pc = 16'h0100;
    chk("fl_addr", 32'(mem_addr), 32'h0100);
    chk("fl_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fl_stale", 32'(instr_valid), 32'd0);
    end
    @(negedge clk);
    chk("fl_issue", 32'(instr_valid), 32'd1);
    check_issue(16'h0100);

    // Reset while holding IR=0xFFFF.
    lat = 1;
    do_ack(1'b1, 16'hFFFF);
    wait_issue("wait_ffff");
    check_issue(16'hFFFF);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_state("rst_iss");
    reset_n = 1'b1;
    exp_pc  = 16'h0000;
    wait_issue("wait_after_rst");
    check_issue(16'h0000);

    // PC wrap from 0xFFFF to 0x0000.
    do_ack(1'b1, 16'hFFFF);
    wait_issue("wait_ffff2");
    check_issue(16'hFFFF);
    do_ack(1'b0, 16'h0000);
    chk("wrap_addr", 32'(mem_addr), 32'h0000);
    wait_issue("wait_wrap");
    check_issue(16'h0000);

    // Randomized flow: acks, branches, flushes in either state.
    for (int it = 0; it < 40; it++) begin
      lat = int'($urandom_range(1, 4));
      br  = 1'($urandom_range(0, 1));
      tgt = 16'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        flush = 1'b1; instr_ack = 1'($urandom_range(0, 1));
        branch_taken = br; branch_target = tgt;
        @(negedge clk);
        flush = 1'b0; instr_ack = 1'b0; branch_taken = 1'b0;
        exp_pc = tgt;
        chk("rnd_fl_addr", 32'(mem_addr), 32'(exp_pc));
      end else begin
        do_ack(br, tgt);
      end
      if ($urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(0, 4));
        repeat (k) @(negedge clk);
        tgt = 16'($urandom);
        flush = 1'b1; branch_target = tgt;
        @(negedge clk);
        flush = 1'b0;
        exp_pc = tgt;
      end
      wait_issue("rnd_wait");
      check_issue(exp_pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Fetches 16-bit instructions from program memory over a valid-based read handshake, holds each one in an instruction register, and splits it into the fields used by the execute datapath. Its `opCode` and `imm8` outputs drive the sign extender directly; `rdest`/`rsrc_imm` drive the register-file read ports. It owns the program counter and applies branch redirects and flushes from the control unit.

## Interface
Parameters:
- `WIDTH`, 16, instruction and data width.
- `ADDR_WIDTH`, 16, program-memory address width.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `mem_req`  out  1  read request to program memory.
- `mem_addr`  out  ADDR_WIDTH  read address; equals `pc` while `mem_req`=1.
- `mem_rdata`  in  WIDTH  read data; sampled only when `mem_valid`=1.
- `mem_valid`  in  1  read-data-valid strobe, one cycle per request.
- `instr_valid`  out  1  decoded fields are valid.
- `instr_ack`  in  1  consumer accepts the current instruction.
- `branch_taken`  in  1  redirect; sampled only with `instr_ack`.
- `flush`  in  1  abort any in-flight fetch and restart at `branch_target`.
- `branch_target`  in  ADDR_WIDTH  redirect/flush address.
- `pc`  out  ADDR_WIDTH  address of the instruction being fetched or held.
- `opCode`  out  4  IR[15:12].
- `rdest`  out  4  IR[11:8].
- `opExt`  out  4  IR[7:4].
- `rsrc_imm`  out  4  IR[3:0].
- `imm8`  out  8  IR[7:0], raw, unextended.

## Operation
- States: `FETCH` and `ISSUE`, plus a `squash` flag register.
- Reset (`reset_n`=0 at an edge): state is `FETCH`, `pc`=`RESET_PC`, IR=0, `squash`=0, `instr_valid`=0. All field outputs are 0.
- `FETCH`:
  - `mem_req`=1 and `mem_addr`=`pc`, held until `mem_valid`.
  - On `mem_valid` with `squash`=0: IR<=`mem_rdata` and the state moves to `ISSUE`.
  - On `mem_valid` with `squash`=1: data is dropped, `squash`<=0, and the state stays in `FETCH` with the new `pc`.
- `ISSUE`:
  - `instr_valid`=1 and `mem_req`=0. Fields are held stable until acknowledged.
  - On `instr_ack`: `pc`<=`branch_taken` ? `branch_target` : `pc`+1, and the state moves to `FETCH`.
- `flush`:
  - In `ISSUE`: `pc`<=`branch_target`, the state moves to `FETCH`, and `instr_ack` is ignored.
  - In `FETCH` with no `mem_valid` that cycle: `pc`<=`branch_target` and `squash`<=1.
  - In `FETCH` with `mem_valid` the same cycle: data is dropped, `pc`<=`branch_target`, and `squash` stays 0.
- PC arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF+1 wraps to 0x0000.
- Field outputs are combinational slices of IR. IR changes only on an accepted `mem_valid`.

## Timing
- Memory latency is at least 1 cycle. `mem_valid` is never asserted in the same cycle `mem_req` first rises.
- Fetch-to-issue: `instr_valid` rises the cycle after the `mem_valid` edge.
- Ack-to-request: `mem_req` rises the cycle after the `instr_ack` edge. Back-to-back throughput is therefore 1 instruction per (latency+2) cycles.
- `instr_valid`, once high, stays high until the `instr_ack` edge or a `flush`.
- Precedence in one cycle: `reset_n`=0 > `flush` > `instr_ack` > `mem_valid`.
- Reset mid-fetch: the outstanding response is not tracked. Memory must also be reset by the same `reset_n`.

## Structure
- Shared package `proc_pkg` holds:
  - state encoding `FETCH`=1'b0, `ISSUE`=1'b1;
  - field-position constants `OP_MSB`=15, `RDEST_MSB`=11, `EXT_MSB`=7, `RSRC_MSB`=3;
  - `INSTR_W`=16.
- One natural sub-module, `pc_reg`, holds the PC with load/increment and wrap. The FSM, IR and squash flag stay in the top module.

## Test plan
- Reset, then memory latency 2 with word 0x5A83 at 0x0000 → `mem_addr`=0x0000; `instr_valid` rises 3 cycles after reset release; `opCode`=0x5, `rdest`=0xA, `opExt`=0x8, `rsrc_imm`=0x3, `imm8`=0x83.
- Ack with `branch_taken`=1, `branch_target`=0x0040 → next `mem_addr`=0x0040. Ack with `branch_taken`=0 at `pc`=0x0040 → next fetch at 0x0041.
- `pc`=0xFFFF, ack without branch → next fetch at 0x0000.
- `flush` to 0x0100 one cycle after `mem_req` (latency 3) → the stale word never raises `instr_valid`; the next accepted fetch is from 0x0100.
- Hold `instr_ack`=0 for 10 cycles in `ISSUE` → `instr_valid` and all fields stay constant and `mem_req` stays 0. Apply `flush` and `instr_ack` together → the redirect goes to `branch_target` and the ack is ignored.
- `reset_n`=0 while in `ISSUE` with IR=0xFFFF → next cycle `instr_valid`=0, all fields 0, `pc`=`RESET_PC`.
